// File: rtl/fxp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : fxp_sqrt_iter
// Description : Multi-cycle fixed-point square root with valid/ready handshakes.
//               It resolves BPC root bits per clock on one shared
//               digit-by-digit datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_sqrt_iter #(
    parameter int WII   = 10,
    parameter int WIF   = 10,
    parameter int WOI   = 6,
    parameter int WOF   = 12,
    parameter int ROUND = 1,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WII+WIF-1:0]   in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow,
    output logic                 busy
);

    localparam int WI   = WII + WIF;
    localparam int WO   = WOI + WOF;
    localparam int FB   = WOF + ROUND;
    localparam int NR   = WII / 2 + FB;
    localparam int ITER = (NR + BPC - 1) / BPC;
    localparam int NS   = ITER * BPC;
    localparam int RW   = 2 * NR;
    localparam int SW   = 2 * NS;
    localparam int RMW  = NR + 2;
    localparam int AW   = RMW + 2;
    localparam int NR1  = NR + 1;
    localparam int SHL  = 2 * FB - WIF;
    localparam int CNTW = $clog2(ITER + 1);
    localparam int CMPW = ((NR + 1) > WO) ? (NR + 2) : (WO + 1);

    localparam logic [CMPW-1:0] C_MAX = CMPW'({(WO-1){1'b1}});
    localparam logic [WO-1:0]   C_SAT = {1'b0, {(WO-1){1'b1}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [SW-1:0]   r_rad;
    logic [SW-1:0]   w_rad_nx;
    logic [RMW-1:0]  r_rem;
    logic [RMW-1:0]  w_rem_nx;
    logic [NR-1:0]   r_root;
    logic [NR-1:0]   w_root_nx;
    logic [CNTW-1:0] r_cnt;
    logic            r_neg;
    logic [WO-1:0]   r_out;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [WI-2:0]   w_mag;
    logic [RW-1:0]   w_rad_init;
    logic [AW-1:0]   w_acc;
    logic [AW-1:0]   w_trial;
    logic [NR:0]     w_rnd;
    logic [CMPW-1:0] w_rnd_ext;
    logic            w_sat;
    logic [WO-1:0]   w_res;
    logic            w_res_ovf;

    assign w_mag = in[WI-2:0];

    // Align the radicand so it carries exactly 2*(WOF+ROUND) fractional bits.
    generate
        if (SHL >= 0) begin : g_shl
            assign w_rad_init = RW'(w_mag) << SHL;
        end else begin : g_shr
            localparam int SHR = -SHL;
            logic [WI-2:0] w_mag_sh;
            assign w_mag_sh   = w_mag >> SHR;
            assign w_rad_init = RW'(w_mag_sh);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nx = S_CALC;
            S_CALC:  if (w_last)    w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = rstn;
            S_CALC:  busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNTW'(ITER - 1));

    // ------------------------------------------------------------------------
    // Digit-by-digit step, unrolled BPC times. The radicand is zero-padded at
    // the top so that when NR is not a multiple of BPC, the spare leading
    // steps only produce zero root bits.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rad_nx  = r_rad;
        w_rem_nx  = r_rem;
        w_root_nx = r_root;
        w_acc     = '0;
        w_trial   = '0;
        for (int k = 0; k < BPC; k++) begin
            w_acc   = {w_rem_nx, w_rad_nx[SW-1 -: 2]};
            w_trial = AW'({w_root_nx, 2'b01});
            if (w_acc >= w_trial) begin
                w_rem_nx  = RMW'(w_acc - w_trial);
                w_root_nx = {w_root_nx[NR-2:0], 1'b1};
            end else begin
                w_rem_nx  = w_acc[RMW-1:0];
                w_root_nx = {w_root_nx[NR-2:0], 1'b0};
            end
            w_rad_nx = w_rad_nx << 2;
        end
    end

    // Rounding can carry into bit NR, so the comparison runs one bit wider.
    assign w_rnd     = ({1'b0, w_root_nx} + NR1'(ROUND)) >> ROUND;
    assign w_rnd_ext = CMPW'(w_rnd);
    assign w_sat     = (w_rnd_ext > C_MAX);

    always_comb begin
        w_res     = WO'(w_rnd_ext);
        w_res_ovf = 1'b0;
        if (r_neg) begin
            w_res     = '0;
            w_res_ovf = 1'b1;
        end else if (w_sat) begin
            w_res     = C_SAT;
            w_res_ovf = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers. Negative inputs still run the full iteration count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_out  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_rad  <= in[WI-1] ? '0 : SW'(w_rad_init);
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_neg  <= in[WI-1];
        end else if (r_state == S_CALC) begin
            r_rad  <= w_rad_nx;
            r_rem  <= w_rem_nx;
            r_root <= w_root_nx;
            r_cnt  <= r_cnt + CNTW'(1);
            if (w_last) begin
                r_out <= w_res;
                r_ovf <= w_res_ovf;
            end
        end
    end

    assign out      = r_out;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fxp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fxp_sqrt_iter
// Description : Self-checking bench for fxp_sqrt_iter (BPC 1/2/4 and WOI=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fxp_sqrt_iter;

    localparam int WIF   = 10;
    localparam int WOF   = 12;
    localparam int ROUND = 1;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [19:0] din       = '0;

    logic [3:0]  rdy, vld, ovf, bsy;
    logic [17:0] o0, o1, o2;
    logic [15:0] o3;
    logic [31:0] outs [4];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    bit          got  [4];
    int          vcyc [4];
    logic [31:0] res  [4];
    logic        rov  [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxp_sqrt_iter #(.BPC(1)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy[0]), .in(din),
        .out_valid(vld[0]), .out_ready(out_ready), .out(o0), .overflow(ovf[0]), .busy(bsy[0]));
    fxp_sqrt_iter #(.BPC(2)) u_b2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy[1]), .in(din),
        .out_valid(vld[1]), .out_ready(out_ready), .out(o1), .overflow(ovf[1]), .busy(bsy[1]));
    fxp_sqrt_iter #(.BPC(4)) u_b4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy[2]), .in(din),
        .out_valid(vld[2]), .out_ready(out_ready), .out(o2), .overflow(ovf[2]), .busy(bsy[2]));
    fxp_sqrt_iter #(.WOI(4)) u_w4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy[3]), .in(din),
        .out_valid(vld[3]), .out_ready(out_ready), .out(o3), .overflow(ovf[3]), .busy(bsy[3]));

    assign outs[0] = 32'(o0);
    assign outs[1] = 32'(o1);
    assign outs[2] = 32'(o2);
    assign outs[3] = 32'(o3);

    // Capture the first result each instance presents after a sample is sent.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rstn) begin
                got[i] = 1'b0;
            end else if (vld[i] && !got[i]) begin
                got[i]  = 1'b1;
                vcyc[i] = cyc;
                res[i]  = outs[i];
                rov[i]  = ovf[i];
            end
        end
    end

    // Reference: integer square root of the scaled radicand by bisection,
    // then round half-up and saturate. Bit 32 carries the overflow flag.
    function automatic longint ref_sqrt(input logic [19:0] x, input int woi);
        longint rad, lo, hi, mid, q, maxv;
        if (x[19]) return 64'h1_0000_0000;
        rad = longint'(x) << (2 * (WOF + ROUND) - WIF);
        lo  = 0;
        hi  = 64'd1 << 20;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= rad) lo = mid;
            else                  hi = mid;
        end
        q    = (ROUND != 0) ? ((lo + 1) >> 1) : lo;
        maxv = (64'd1 << (woi + WOF - 1)) - 1;
        if (q > maxv) return (64'd1 << 32) | maxv;
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (rdy != 4'hF && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(rdy), 32'hF);
    endtask

    task automatic run_sample(input logic [19:0] x);
        int     n, acc;
        longint e6, e4;
        int     iters [4];
        iters = '{18, 9, 5, 18};
        wait_ready();
        for (int i = 0; i < 4; i++) got[i] = 1'b0;
        din      = x;
        in_valid = 1'b1;
        @(negedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        n = 0;
        while (!(got[0] && got[1] && got[2] && got[3]) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("result_wait", 32'(got[0] && got[1] && got[2] && got[3]), 32'd1);
        e6 = ref_sqrt(x, 6);
        e4 = ref_sqrt(x, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out[%0d] in=%05h", i, x), res[i], 32'(i == 3 ? e4 : e6) & 32'hFFFFFFFF);
            chk($sformatf("ovf[%0d] in=%05h", i, x), 32'(rov[i]),
                32'(i == 3 ? e4[32] : e6[32]));
            // Latency counted in clock edges, the accept edge included.
            chk($sformatf("lat[%0d]", i), 32'(vcyc[i] - acc + 1), 32'(iters[i] + 1));
        end
    endtask

    logic [19:0] rx;
    longint      ebp;
    bit          stale;

    initial begin
        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(rdy[0]), 32'd0);
        chk("rst_out_valid", 32'(vld[0]), 32'd0);
        chk("rst_out",       32'(o0),     32'd0);
        chk("rst_overflow",  32'(ovf[0]), 32'd0);
        chk("rst_busy",      32'(bsy[0]), 32'd0);
        rstn = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", 32'(rdy[0]), 32'd1);

        // Directed values
        run_sample(20'h01000);
        chk("t1_out", res[0], 32'h02000);
        chk("t1_ovf", 32'(rov[0]), 32'd0);
        run_sample(20'h7FFFF);
        chk("t2_max_out", res[0], 32'h16A0A);
        chk("t2_max_ovf", 32'(rov[0]), 32'd0);
        run_sample(20'h00000);
        chk("t2_zero_out", res[0], 32'd0);
        chk("t2_zero_ovf", 32'(rov[0]), 32'd0);
        run_sample(20'h19000);
        chk("t3_sat_out", res[3], 32'h7FFF);
        chk("t3_sat_ovf", 32'(rov[3]), 32'd1);
        run_sample(20'h80000);
        chk("t3_neg_out", res[0], 32'd0);
        chk("t3_neg_ovf", 32'(rov[0]), 32'd1);

        // Backpressure: hold the result for 10 clocks while in_valid pulses.
        wait_ready();
        for (int i = 0; i < 4; i++) got[i] = 1'b0;
        out_ready = 1'b0;
        din       = 20'h0A000;
        ebp       = ref_sqrt(20'h0A000, 6);
        in_valid  = 1'b1;
        @(negedge clk); #1;
        in_valid  = 1'b0;
        for (int n = 0; n < 200 && !vld[0]; n++) begin
            @(negedge clk); #1;
        end
        chk("bp_valid_wait", 32'(vld[0]), 32'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            din      = 20'($urandom) & 20'h7FFFF;
            @(negedge clk); #1;
            chk("bp_valid",    32'(vld[0]), 32'd1);
            chk("bp_out",      32'(o0),     32'(ebp) & 32'h3FFFF);
            chk("bp_ovf",      32'(ovf[0]), 32'(ebp[32]));
            chk("bp_in_ready", 32'(rdy[0]), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_single_xfer", 32'(vld[0]), 32'd0);
        chk("bp_ready_after", 32'(rdy[0]), 32'd1);

        // Reset in the middle of an iteration
        wait_ready();
        din      = 20'h12345;
        in_valid = 1'b1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid_busy", 32'(bsy[0]), 32'd1);
        rstn = 1'b0;
        @(negedge clk); #1;
        chk("mr_out_valid", 32'(vld[0]), 32'd0);
        chk("mr_busy",      32'(bsy[0]), 32'd0);
        chk("mr_in_ready",  32'(rdy[0]), 32'd0);
        rstn  = 1'b1;
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk); #1;
            if (vld != 4'h0) stale = 1'b1;
        end
        chk("mr_no_stale_valid", 32'(stale), 32'd0);
        run_sample(20'h12345);

        // Random stream, identical across BPC = 1, 2, 4
        for (int s = 0; s < 43; s++) begin
            rx = 20'($urandom);
            if (s % 3 != 0) rx[19] = 1'b0;
            if (s % 7 == 0) rx = rx >> 10;
            run_sample(rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
